// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - execute-stage ALU with iterative multiply/divide unit and HI/LO registers
module alu_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  input  logic [4:0]               ALUOp,
  input  logic [$clog2(WIDTH)-1:0] Shamt,
  input  logic                     ALUOv,
  input  logic                     DM_Ov,
  input  logic [3:0]               MDOp,
  input  logic                     Req,
  output logic [WIDTH-1:0]         ALURes,
  output logic                     Exc_Ov,
  output logic                     Exc_Ov_DM,
  output logic                     Start,
  output logic                     Busy,
  output logic [WIDTH-1:0]         HI,
  output logic [WIDTH-1:0]         LO
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SLT  = 5'd4;
  localparam logic [4:0] OP_SLTU = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_NOR  = 5'd7;
  localparam logic [4:0] OP_SLL  = 5'd8;
  localparam logic [4:0] OP_SRL  = 5'd9;
  localparam logic [4:0] OP_SRA  = 5'd10;

  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic            res_wr_q, res_wr_d;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             ovf;

  logic             is_mul;
  logic             is_md_start;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;
  logic             div_zero;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // Single-cycle ALU; overflow judged on the sign-extended WIDTH+1 bit sum/difference
  always_comb begin
    sum_ext  = {A[WIDTH-1], A} + {B[WIDTH-1], B};
    diff_ext = {A[WIDTH-1], A} - {B[WIDTH-1], B};
    alu_res  = '0;
    ovf      = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        ovf     = sum_ext[WIDTH] != sum_ext[WIDTH-1];
      end
      OP_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        ovf     = diff_ext[WIDTH] != diff_ext[WIDTH-1];
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_SLL:  alu_res = B << Shamt;
      OP_SRL:  alu_res = B >> Shamt;
      OP_SRA:  alu_res = $unsigned($signed(B) >>> Shamt);
      default: alu_res = '0;
    endcase
  end

  // Result steering and exception flags; MFHI/MFLO always see the committed HI/LO
  always_comb begin
    Exc_Ov    = ALUOv & ovf;
    Exc_Ov_DM = DM_Ov & ovf;
    if (MDOp == MD_MFHI)      ALURes = hi_q;
    else if (MDOp == MD_MFLO) ALURes = lo_q;
    else                      ALURes = alu_res;
  end

  // Multiply/divide datapath computed on magnitudes so MIN/-1 and remainder sign fall out naturally
  always_comb begin
    is_md_start = (MDOp == MD_MULT) || (MDOp == MD_MULTU) ||
                  (MDOp == MD_DIV)  || (MDOp == MD_DIVU);
    is_mul      = (MDOp == MD_MULT) || (MDOp == MD_MULTU);
    is_signed   = (MDOp == MD_MULT) || (MDOp == MD_DIV);
    a_neg       = is_signed & A[WIDTH-1];
    b_neg       = is_signed & B[WIDTH-1];
    a_mag       = a_neg ? (~A + 1'b1) : A;
    b_mag       = b_neg ? (~B + 1'b1) : B;
    prod_mag    = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    prod        = (a_neg ^ b_neg) ? (~prod_mag + 1'b1) : prod_mag;
    div_zero    = (B == '0);
    divisor     = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag       = a_mag / divisor;
    r_mag       = a_mag % divisor;
    quot        = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem         = a_neg ? (~r_mag + 1'b1) : r_mag;
    Start       = is_md_start & ~Req & (state_q == S_IDLE);
  end

  // Next-state logic: capture result at start, count down, commit HI/LO on the last busy cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_BUSY;
          if (is_mul) begin
            cnt_d    = CW'(MUL_CYCLES);
            res_hi_d = prod[2*WIDTH-1:WIDTH];
            res_lo_d = prod[WIDTH-1:0];
            res_wr_d = 1'b1;
          end else begin
            cnt_d    = CW'(DIV_CYCLES);
            res_hi_d = rem;
            res_lo_d = quot;
            res_wr_d = ~div_zero;
          end
        end else if (!Req) begin
          if (MDOp == MD_MTHI) hi_d = A;
          if (MDOp == MD_MTLO) lo_d = A;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          if (res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and HI/LO registers; reset abandons any operation in flight without writing HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
    end
  end

  assign Busy = (state_q == S_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Next-generation execute-stage arithmetic block for the pipelined MIPS core. It combines the following, parametrised in datapath width and multiply/divide latency:
- a width-generic single-cycle ALU with add/sub overflow exception flags;
- an iterative multiply/divide unit with HI/LO registers, a busy handshake and interrupt-request cancellation.
It sits in the E stage; its Busy/Start outputs feed the hazard unit's stall logic.

Parameters:
WIDTH, 32, datapath width of A, B, ALURes, HI, LO (>= 8)
MUL_CYCLES, 5, busy cycles for MULT/MULTU (>= 1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>= 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
A  input  WIDTH  operand A (rs)
B  input  WIDTH  operand B (rt or immediate)
ALUOp  input  5  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLTU, 6 XOR, 7 NOR, 8 SLL, 9 SRL, 10 SRA; others give 0
Shamt  input  $clog2(WIDTH)  shift amount for SLL/SRL/SRA (shifts B)
ALUOv  input  1  instruction traps on arithmetic overflow (add/sub)
DM_Ov  input  1  instruction is a load/store; overflow means address exception
MDOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO
Req  input  1  exception/interrupt flush this cycle; suppresses MD side effects
ALURes  output  WIDTH  ALU result; replaced by HI/LO for MFHI/MFLO
Exc_Ov  output  1  arithmetic overflow exception
Exc_Ov_DM  output  1  address-calculation overflow exception
Start  output  1  combinational: a MULT/MULTU/DIV/DIVU is issued this cycle
Busy  output  1  registered: MD unit computing
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register

Behaviour:
- Reset: HI = LO = 0, Busy = 0, counter = 0, state IDLE. Takes priority over every other event in the same cycle, including cancelling an operation in flight with no HI/LO write.
- ALU is purely combinational, zero latency:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is signed; SLTU is unsigned; both give a result of 0 or 1, zero-extended.
  - SRA is arithmetic; SLL/SRL fill with zeros.
- Overflow detection:
  - Sign-extend A and B to WIDTH+1 bits and form the sum/difference.
  - ovf = (ALUOp==ADD && bit[WIDTH]!=bit[WIDTH-1]) || (ALUOp==SUB && same test on the difference).
  - Exc_Ov = ALUOv & ovf. Exc_Ov_DM = DM_Ov & ovf.
  - Both flags are 0 for all other ops.
  - ALURes still shows the wrapped value when a flag is set.
- ALURes source: MFHI gives HI, MFLO gives LO, otherwise the ALU result.
- Start = (MDOp in {1..4}) & ~Req & ~Busy.
- State machine IDLE/BUSY:
  - IDLE -> BUSY on Start. At that edge:
    - capture the full result into internal registers: 2*WIDTH-bit product; quotient to LO, remainder to HI;
    - load the counter with MUL_CYCLES or DIV_CYCLES.
  - BUSY: the counter decrements each cycle. When counter==1, at that edge write HI/LO from the captured result, clear Busy and return to IDLE.
  - Busy is high for exactly MUL_CYCLES / DIV_CYCLES cycles, starting the cycle after Start.
  - HI/LO show the new values in the first cycle Busy is low.
- Arithmetic rules:
  - MULT/DIV are signed; MULTU/DIVU are unsigned.
  - Division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: the unit runs the full DIV_CYCLES, then leaves HI/LO unchanged.
  - Signed most-negative / -1: LO = most-negative, HI = 0.
- Req does not cancel an operation already in BUSY; it runs to completion.
- An MD start MDOp while Busy is ignored; the hazard unit guarantees this does not occur.
- MTHI/MTLO:
  - write A into HI/LO at the edge when MDOp matches, ~Req and ~Busy;
  - a write accepted while Busy is high is ignored.
- MFHI/MFLO while Busy return the current (old) HI/LO; stalling is the hazard unit's job.

Test Plan:
1. WIDTH=32, ADD with A=0x7FFFFFFF, B=1, ALUOv=1 -> ALURes=0x80000000, Exc_Ov=1, Exc_Ov_DM=0. Same with DM_Ov=1, ALUOv=0 -> Exc_Ov_DM=1. SUB with A=0x80000000, B=1 -> ovf. SLTU with 0xFFFFFFFF, 1 -> 0; SLT -> 1.
2. MULT with A=0xFFFFFFFE (-2), B=3 -> Start=1. Busy is high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
3. DIV with A=-7, B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with B=0 -> Busy for 10 cycles, HI/LO unchanged.
4. MTHI with A=0x1234 and Req=1 -> HI unchanged, Start=0. Req asserted in the 2nd busy cycle of a MULT -> result still committed at cycle 5.
5. Reset asserted in busy cycle 3 of a DIV -> next cycle Busy=0, HI=LO=0, and no later write occurs.
6. Rerun with WIDTH=16, MUL_CYCLES=1:
   - MULTU 0xFFFF*0xFFFF -> Busy for 1 cycle, HI=0xFFFE, LO=0x0001.
   - SRA of 0x8000 by 4 -> 0xF800.
